// File: rtl/stream_combiner_if.sv
// Handshake bundle for the two-input stream combiner: A0 and A1 sink sides, B source side.
// The slave view belongs to the combiner; the master view belongs to whatever drives it.
interface stream_combiner_if #(
  parameter int WIDTH0 = 32,
  parameter int WIDTH1 = 32
);
  logic                     iValid_AM0;
  logic                     oReady_AM0;
  logic [WIDTH0-1:0]        iData_AM0;
  logic                     iValid_AM1;
  logic                     oReady_AM1;
  logic [WIDTH1-1:0]        iData_AM1;
  logic                     oValid_BM;
  logic                     iReady_BM;
  logic [WIDTH1+WIDTH0-1:0] oData_BM;

  modport slave (
    input  iValid_AM0, iData_AM0,
    input  iValid_AM1, iData_AM1,
    input  iReady_BM,
    output oReady_AM0, oReady_AM1,
    output oValid_BM, oData_BM
  );

  modport master (
    output iValid_AM0, iData_AM0,
    output iValid_AM1, iData_AM1,
    output iReady_BM,
    input  oReady_AM0, oReady_AM1,
    input  oValid_BM, oData_BM
  );
endinterface

// File: rtl/stream_combiner.sv
// Joins one beat from A0 and one from A1 into a single B beat {A0, A1}.
// One holding slot per input; registered output stage, either main+skid (BURST="yes") or a single entry.
module stream_combiner #(
  parameter int    WIDTH0 = 32,
  parameter int    WIDTH1 = 32,
  parameter string BURST  = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  stream_combiner_if.slave bus
);
  localparam int WOUT = WIDTH1 + WIDTH0;

  logic              slot0V;
  logic              slot1V;
  logic [WIDTH0-1:0] slot0D;
  logic [WIDTH1-1:0] slot1D;
  logic              mainV;
  logic [WOUT-1:0]   mainD;
  logic              outRdy;
  logic              joinNow;
  logic              accept0;
  logic              accept1;
  logic              drain;
  logic [WOUT-1:0]   joinD;

  assign joinNow = slot0V && slot1V && outRdy;
  assign joinD   = {slot0D, slot1D};
  assign drain   = mainV && bus.iReady_BM;

  // Readies come from registered state only; the reset term forces them low during reset.
  assign bus.oReady_AM0 = iRST && (!slot0V || joinNow);
  assign bus.oReady_AM1 = iRST && (!slot1V || joinNow);
  assign accept0        = bus.iValid_AM0 && bus.oReady_AM0;
  assign accept1        = bus.iValid_AM1 && bus.oReady_AM1;

  assign bus.oValid_BM = mainV;
  assign bus.oData_BM  = mainD;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      slot0V <= 1'b0;
      slot0D <= '0;
      slot1V <= 1'b0;
      slot1D <= '0;
    end else begin
      if (accept0) begin
        slot0D <= bus.iData_AM0;
        slot0V <= 1'b1;
      end else if (joinNow) begin
        slot0V <= 1'b0;
      end
      if (accept1) begin
        slot1D <= bus.iData_AM1;
        slot1V <= 1'b1;
      end else if (joinNow) begin
        slot1V <= 1'b0;
      end
    end
  end

  generate
    if (BURST == "yes") begin : genBurst
      logic            skidV;
      logic [WOUT-1:0] skidD;

      assign outRdy = !skidV;

      // A join is only possible with the skid empty, so skid refill and join never coincide.
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
          mainV <= 1'b0;
          mainD <= '0;
          skidV <= 1'b0;
          skidD <= '0;
        end else if (drain) begin
          if (skidV) begin
            mainD <= skidD;
            skidV <= 1'b0;
          end else if (joinNow) begin
            mainD <= joinD;
          end else begin
            mainV <= 1'b0;
          end
        end else if (joinNow) begin
          if (!mainV) begin
            mainD <= joinD;
            mainV <= 1'b1;
          end else begin
            skidD <= joinD;
            skidV <= 1'b1;
          end
        end
      end
    end else begin : genSingle
      assign outRdy = !mainV;

      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
          mainV <= 1'b0;
          mainD <= '0;
        end else if (drain) begin
          mainV <= 1'b0;
        end else if (joinNow) begin
          mainD <= joinD;
          mainV <= 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_stream_combiner.sv
// Directed bench for stream_combiner: one burst and one non-burst instance sharing stimulus.
// sel picks which instance the stimulus drives and which outputs are observed.
`timescale 1ns/1ps
module tb_stream_combiner;
  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        sel  = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rdyB = 1'b0;
  logic [7:0]  d0 = '0, d1 = '0;
  logic        r0, r1, ov;
  logic [15:0] od;
  int          nCompared   = 0;
  int          nMismatched = 0;

  always #5 iCLK = ~iCLK;

  stream_combiner_if #(.WIDTH0(8), .WIDTH1(8)) ifB ();
  stream_combiner_if #(.WIDTH0(8), .WIDTH1(8)) ifN ();

  stream_combiner #(.WIDTH0(8), .WIDTH1(8), .BURST("yes")) dutB (
    .iCLK(iCLK), .iRST(iRST), .bus(ifB)
  );
  stream_combiner #(.WIDTH0(8), .WIDTH1(8), .BURST("no")) dutN (
    .iCLK(iCLK), .iRST(iRST), .bus(ifN)
  );

  assign ifB.iValid_AM0 = sel ? 1'b0 : v0;
  assign ifB.iValid_AM1 = sel ? 1'b0 : v1;
  assign ifB.iReady_BM  = sel ? 1'b0 : rdyB;
  assign ifB.iData_AM0  = d0;
  assign ifB.iData_AM1  = d1;
  assign ifN.iValid_AM0 = sel ? v0 : 1'b0;
  assign ifN.iValid_AM1 = sel ? v1 : 1'b0;
  assign ifN.iReady_BM  = sel ? rdyB : 1'b0;
  assign ifN.iData_AM0  = d0;
  assign ifN.iData_AM1  = d1;

  assign r0 = sel ? ifN.oReady_AM0 : ifB.oReady_AM0;
  assign r1 = sel ? ifN.oReady_AM1 : ifB.oReady_AM1;
  assign ov = sel ? ifN.oValid_BM  : ifB.oValid_BM;
  assign od = sel ? ifN.oData_BM   : ifB.oData_BM;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Offers n pairs (A0=i, A1=0x80+i); holds B stalled for the first stallCycles cycles.
  task automatic runPairs(input int n, input int expectGap, input int stallCycles, input string tag);
    int inIdx0 = 0, inIdx1 = 0, outIdx = 0, cyc = 0, lastCyc = -1;
    logic acc0, acc1;
    logic [15:0] expD;
    while (outIdx < n && cyc < 400) begin
      rdyB = (cyc >= stallCycles);
      v0 = (inIdx0 < n);
      d0 = 8'(inIdx0);
      v1 = (inIdx1 < n);
      d1 = 8'(8'h80 + inIdx1);
      if (stallCycles > 0 && cyc == stallCycles) begin
        checkVal({tag, " accepted0"}, 32'(inIdx0), 32'd3);
        checkVal({tag, " accepted1"}, 32'(inIdx1), 32'd3);
        checkVal({tag, " ready0 low"}, 32'(r0), 32'd0);
        checkVal({tag, " ready1 low"}, 32'(r1), 32'd0);
      end
      if (ov && !rdyB)
        checkVal({tag, " stalled data"}, 32'(od), 32'h0080);
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      if (ov && rdyB) begin
        expD = {8'(outIdx), 8'(8'h80 + outIdx)};
        checkVal($sformatf("%s beat%0d", tag, outIdx), 32'(od), 32'(expD));
        if (lastCyc >= 0)
          checkVal($sformatf("%s gap%0d", tag, outIdx), 32'(cyc - lastCyc), 32'(expectGap));
        lastCyc = cyc;
        outIdx++;
      end
      tick();
      cyc++;
      if (acc0) inIdx0++;
      if (acc1) inIdx1++;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    checkVal({tag, " beat count"}, 32'(outIdx), 32'(n));
    tick();
    tick();
    checkVal({tag, " idle after"}, 32'(ov), 32'd0);
  endtask

  initial begin
    int beats;
    // Reset state on both instances
    tick();
    tick();
    checkVal("rst B valid", 32'(ifB.oValid_BM), 32'd0);
    checkVal("rst B data", 32'(ifB.oData_BM), 32'd0);
    checkVal("rst B ready0", 32'(ifB.oReady_AM0), 32'd0);
    checkVal("rst B ready1", 32'(ifB.oReady_AM1), 32'd0);
    checkVal("rst N valid", 32'(ifN.oValid_BM), 32'd0);
    checkVal("rst N ready0", 32'(ifN.oReady_AM0), 32'd0);
    iRST = 1'b1;

    // Simultaneous inputs
    sel = 1'b0; rdyB = 1'b1;
    v0 = 1'b1; d0 = 8'h12; v1 = 1'b1; d1 = 8'h34;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    checkVal("simul no valid yet", 32'(ov), 32'd0);
    tick();
    checkVal("simul valid", 32'(ov), 32'd1);
    checkVal("simul data", 32'(od), 32'h1234);
    tick();
    checkVal("simul one cycle", 32'(ov), 32'd0);

    // Staggered inputs
    v0 = 1'b1; d0 = 8'hAA;
    tick();
    v0 = 1'b0;
    for (int e = 0; e < 5; e++) begin
      checkVal($sformatf("stag ready0 low e%0d", e), 32'(r0), 32'd0);
      checkVal($sformatf("stag no valid e%0d", e), 32'(ov), 32'd0);
      if (e < 4) tick();
    end
    v1 = 1'b1; d1 = 8'hBB;
    tick();
    v1 = 1'b0;
    checkVal("stag ready0 at join", 32'(r0), 32'd1);
    tick();
    checkVal("stag valid", 32'(ov), 32'd1);
    checkVal("stag data", 32'(od), 32'hAABB);
    checkVal("stag ready0 back", 32'(r0), 32'd1);
    tick();

    runPairs(16, 1, 0, "burst");
    runPairs(5, 1, 8, "bp");

    sel = 1'b1;
    runPairs(16, 2, 0, "nonburst");
    sel = 1'b0;

    // Reset mid-operation with two beats buffered in the burst instance
    rdyB = 1'b0;
    v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
    tick();
    d0 = 8'h33; d1 = 8'h44;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    tick();
    checkVal("mid full valid", 32'(ov), 32'd1);
    #2 iRST = 1'b0;
    #1;
    checkVal("mid rst valid", 32'(ov), 32'd0);
    checkVal("mid rst ready0", 32'(r0), 32'd0);
    checkVal("mid rst ready1", 32'(r1), 32'd0);
    checkVal("mid rst data", 32'(od), 32'd0);
    tick();
    iRST = 1'b1;
    rdyB = 1'b1;
    v0 = 1'b1; d0 = 8'h55; v1 = 1'b1; d1 = 8'h66;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      if (ov) begin
        checkVal("post rst data", 32'(od), 32'h5566);
        beats++;
      end
      tick();
    end
    checkVal("post rst beats", 32'(beats), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
